fifo_read_port: RTL and testbench

//  Read-side drain engine for the FIFO pointer controller and its stack memory.
//  - Watches stack_empty and issues read_from_stack pulses.
//  - Captures the stack data returned one cycle later into a small output buffer.
//  - Presents that data downstream as a valid/ready stream, sustaining 1 word/cycle under no backpressure.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_out_buf.sv | 65 ++++++
 rtl/fifo_read_port.sv | 73 +++++++
 tb/tb_fifo_read_port.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer controller and its read port.
// Provides the default stack geometry and a helper that sizes occupancy
// counters able to hold every value from 0 up to a given depth.
package fifo_pkg;

    localparam int unsigned STACK_WIDTH     = 8;
    localparam int unsigned STACK_HEIGHT    = 16;
    localparam int unsigned STACK_PTR_WIDTH = 4;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned buf_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Small circular output buffer for the FIFO read port.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   push, push_data write push_data at the tail
//   pop             drop the head entry
//   head_data       word at the head (valid when valid==1)
//   valid           buffer holds at least one entry
//   count           number of entries held
// The caller guarantees no push when full and no pop when empty.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int unsigned width     = STACK_WIDTH,
    parameter int unsigned depth     = 2,
    parameter int unsigned cnt_width = buf_cnt_w(depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [width-1:0]     push_data,
    input  logic                 pop,
    output logic [width-1:0]     head_data,
    output logic                 valid,
    output logic [cnt_width-1:0] count
);

    localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] mem [depth];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_width'(1);
                2'b01:   count <= count - cnt_width'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];
    assign valid     = (count != '0);

endmodule

// File: rtl/fifo_read_port.sv
// Read-side drain engine for the FIFO pointer controller.
// Issues read_from_stack whenever the stack holds data and the output buffer
// (including the read in flight) has room, captures the word the registered
// RAM returns one cycle later, and presents it as a valid/ready stream.
// Ports:
//   clk, rst         clock and synchronous active-low reset
//   stack_empty      empty flag from the FIFO controller
//   read_from_stack  read request to the controller
//   rd_data          RAM data, valid one cycle after read_from_stack
//   out_data         head-of-buffer word
//   out_valid        out_data is valid
//   out_ready        downstream accepts out_data
//   buf_level        buffered entries, excluding the read in flight
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int unsigned stack_width   = STACK_WIDTH,
    parameter int unsigned buf_depth     = 2,
    parameter int unsigned buf_cnt_width = buf_cnt_w(buf_depth)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stack_empty,
    output logic                     read_from_stack,
    input  logic [stack_width-1:0]   rd_data,
    output logic [stack_width-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [buf_cnt_width-1:0] buf_level
);

    localparam logic [buf_cnt_width:0] DEPTH = (buf_cnt_width + 1)'(buf_depth);

    logic                   inflight;
    logic                   pop;
    logic [buf_cnt_width:0] occ;

    assign pop = out_valid & out_ready;

    // One extra bit so buffered + in-flight never overflows the compare.
    assign occ = {1'b0, buf_level} + {{buf_cnt_width{1'b0}}, inflight};

    // A full buffer may still issue when the head leaves this cycle; the
    // returned word then lands in the slot freed by the pop.
    always_comb begin
        read_from_stack = rst & ~stack_empty &
                          ((occ < DEPTH) | ((occ == DEPTH) & pop));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read_from_stack;
        end
    end

    fifo_out_buf #(
        .width     (stack_width),
        .depth     (buf_depth),
        .cnt_width (buf_cnt_width)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (rd_data),
        .pop       (pop),
        .head_data (out_data),
        .valid     (out_valid),
        .count     (buf_level)
    );

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port. A small stack model stands in for the
// FIFO controller and its registered RAM.
module tb_fifo_read_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       stack_empty;
    logic       read_from_stack;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] buf_level;

    // Stack model
    logic [7:0] mem [64];
    int         wptr = 0;
    int         rptr = 0;
    int         reads = 0;
    int         viol = 0;
    logic       empty_ovr = 1'b0;
    logic       flush_on_reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int base;

    always #5 clk = ~clk;

    assign stack_empty = empty_ovr | (wptr == rptr);

    always @(posedge clk) begin
        if (read_from_stack) begin
            rd_data <= mem[rptr % 64];
            rptr    <= rptr + 1;
            reads   <= reads + 1;
            if (stack_empty) viol <= viol + 1;
        end else if (!rst && flush_on_reset) begin
            rptr <= wptr;
        end
    end

    fifo_read_port #(
        .stack_width   (8),
        .buf_depth     (2),
        .buf_cnt_width (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stack_empty     (stack_empty),
        .read_from_stack (read_from_stack),
        .rd_data         (rd_data),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .buf_level       (buf_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wptr % 64] = d;
        wptr = wptr + 1;
    endtask

    initial begin
        rst       = 1'b0;
        out_ready = 1'b1;
        rd_data   = '0;

        // Reset held 3 cycles with a non-empty stack
        push_word(8'hA5);
        #1;
        chk("rst_rfs_pre", {31'b0, read_from_stack}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rfs", {31'b0, read_from_stack}, 0);
            chk("rst_valid", {31'b0, out_valid}, 0);
            chk("rst_level", {30'b0, buf_level}, 0);
            chk("rst_data", {24'b0, out_data}, 0);
        end

        // Single word: pulse at T, data at T+2 for one cycle
        base = reads;
        rst = 1'b1;
        #1;
        chk("single_rfs_T", {31'b0, read_from_stack}, 1);
        step();
        chk("single_rfs_T1", {31'b0, read_from_stack}, 0);
        chk("single_valid_T1", {31'b0, out_valid}, 0);
        step();
        chk("single_valid_T2", {31'b0, out_valid}, 1);
        chk("single_data_T2", {24'b0, out_data}, 32'hA5);
        chk("single_level_T2", {30'b0, buf_level}, 1);
        step();
        chk("single_valid_T3", {31'b0, out_valid}, 0);
        chk("single_reads", reads - base, 1);

        // Streaming: 8 words, no backpressure
        empty_ovr = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(i));
        step();
        base = reads;
        empty_ovr = 1'b0;
        #1;
        chk("stream_rfs_0", {31'b0, read_from_stack}, 1);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i <= 7) chk("stream_rfs", {31'b0, read_from_stack}, 1);
            if (i >= 2) begin
                chk("stream_valid", {31'b0, out_valid}, 1);
                chk("stream_data", {24'b0, out_data}, i - 2);
            end
        end
        step();
        chk("stream_valid_end", {31'b0, out_valid}, 0);
        chk("stream_rfs_end", {31'b0, read_from_stack}, 0);
        chk("stream_reads", reads - base, 8);

        // Backpressure: 10 stalled cycles then drain in order
        out_ready = 1'b0;
        empty_ovr = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(i));
        step();
        base = reads;
        empty_ovr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_reads", reads - base, 2);
        chk("bp_level", {30'b0, buf_level}, 2);
        chk("bp_rfs_stalled", {31'b0, read_from_stack}, 0);
        chk("bp_valid", {31'b0, out_valid}, 1);
        chk("bp_head", {24'b0, out_data}, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_rfs_release", {31'b0, read_from_stack}, 1);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("bp_drain_valid", {31'b0, out_valid}, 1);
            chk("bp_drain_data", {24'b0, out_data}, i);
        end
        step();
        chk("bp_drain_end", {31'b0, out_valid}, 0);
        chk("bp_reads_total", reads - base, 8);

        // Empty boundary: one word, then the stack stays empty
        base = reads;
        push_word(8'h3C);
        #1;
        chk("empty_rfs_T", {31'b0, read_from_stack}, 1);
        step();
        chk("empty_rfs_T1", {31'b0, read_from_stack}, 0);
        step();
        chk("empty_valid_T2", {31'b0, out_valid}, 1);
        chk("empty_data_T2", {24'b0, out_data}, 32'h3C);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("empty_valid_after", {31'b0, out_valid}, 0);
            chk("empty_rfs_after", {31'b0, read_from_stack}, 0);
        end
        chk("empty_reads", reads - base, 1);

        // Toggling empty flag: reads follow the flag cycle by cycle
        out_ready = 1'b0;
        push_word(8'h51);
        push_word(8'h52);
        empty_ovr = 1'b1;
        #1;
        chk("toggle_rfs_masked", {31'b0, read_from_stack}, 0);
        step();
        empty_ovr = 1'b0;
        #1;
        chk("toggle_rfs_open", {31'b0, read_from_stack}, 1);
        step();
        empty_ovr = 1'b1;
        #1;
        chk("toggle_rfs_masked2", {31'b0, read_from_stack}, 0);
        step();
        empty_ovr = 1'b0;
        #1;
        chk("toggle_rfs_open2", {31'b0, read_from_stack}, 1);
        step();
        chk("toggle_head", {24'b0, out_data}, 32'h51);
        out_ready = 1'b1;
        step();
        chk("toggle_second", {24'b0, out_data}, 32'h52);
        chk("toggle_second_valid", {31'b0, out_valid}, 1);
        step();
        chk("toggle_drained", {31'b0, out_valid}, 0);

        // Reset mid-stream with one word buffered and one in flight
        out_ready = 1'b0;
        empty_ovr = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
        step();
        empty_ovr = 1'b0;
        step();
        step();
        chk("mid_level_pre", {30'b0, buf_level}, 1);
        chk("mid_valid_pre", {31'b0, out_valid}, 1);
        rst = 1'b0;
        flush_on_reset = 1'b1;
        #1;
        chk("mid_rfs_in_rst", {31'b0, read_from_stack}, 0);
        step();
        chk("mid_valid_rst", {31'b0, out_valid}, 0);
        chk("mid_level_rst", {30'b0, buf_level}, 0);
        chk("mid_data_rst", {24'b0, out_data}, 0);
        rst = 1'b1;
        flush_on_reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_stale", {31'b0, out_valid}, 0);
            chk("mid_no_read", {31'b0, read_from_stack}, 0);
        end

        chk("no_read_while_empty", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
